// File: rtl/change_delay_capture.sv
// Change-triggered two-stage delayed capture: a change on din starts a sequence
// that captures din into b_out after DLY1 cycles, then copies b_out into c_out DLY2 cycles later.
module change_delay_capture #(
   parameter int WIDTH = 6,
   parameter int DLY1  = 10,
   parameter int DLY2  = 5,
   parameter int MODE  = 0,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] c_out,
   output logic             busy,
   output logic             entry_pulse,
   output logic             exit_pulse,
   output logic [CNTW-1:0]  drop_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT1 = 2'd1,
      WAIT2 = 2'd2
   } state_t;

   localparam logic [7:0] LOAD1   = 8'(DLY1 - 1);
   localparam logic [7:0] LOAD2   = 8'(DLY2 - 1);
   localparam bit         RESTART = (MODE == 1);

   state_t           state_q;
   state_t           state_d;
   logic [7:0]       cnt_q;
   logic [7:0]       cnt_d;
   logic [WIDTH-1:0] din_q;
   logic             chg;
   logic             cnt_zero;
   logic             restart;

   logic [WIDTH-1:0] b_d;
   logic [WIDTH-1:0] c_d;
   logic             busy_d;
   logic             entry_d;
   logic             exit_d;
   logic             drop_inc;

   assign chg      = (din != din_q);
   assign cnt_zero = (cnt_q == 8'd0);
   assign restart  = RESTART && chg && (state_q != IDLE);

   // State register; every output is registered here as well.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         din_q       <= '0;
         b_out       <= '0;
         c_out       <= '0;
         busy        <= 1'b0;
         entry_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         din_q       <= din;
         b_out       <= b_d;
         c_out       <= c_d;
         busy        <= busy_d;
         entry_pulse <= entry_d;
         exit_pulse  <= exit_d;
         if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // Next-state and delay counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (chg) begin
               state_d = WAIT1;
               cnt_d   = LOAD1;
            end
         end
         WAIT1: begin
            if (restart) begin
               state_d = WAIT1;
               cnt_d   = LOAD1;
            end else if (cnt_zero) begin
               state_d = WAIT2;
               cnt_d   = LOAD2;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         WAIT2: begin
            // A restart on the completing edge still finishes the old sequence
            // (handled in the output logic) before re-entering WAIT1.
            if (restart) begin
               state_d = WAIT1;
               cnt_d   = LOAD1;
            end else if (cnt_zero) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      b_d      = b_out;
      c_d      = c_out;
      entry_d  = 1'b0;
      exit_d   = 1'b0;
      drop_inc = 1'b0;
      if ((state_q == WAIT1) && cnt_zero && !restart) begin
         b_d = din;
      end
      if ((state_q == WAIT2) && cnt_zero) begin
         c_d    = b_out;
         exit_d = 1'b1;
      end
      if (chg) begin
         if (state_q == IDLE) begin
            entry_d = 1'b1;
         end else begin
            drop_inc = 1'b1;
            entry_d  = RESTART;
         end
      end
      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_change_delay_capture.sv
// Bench for change_delay_capture: four parameter sets share one stimulus and are
// checked every cycle against an edge-time model, plus directed literal checks.
module tb_change_delay_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] din = 6'd0;

   always #5 clk = ~clk;

   logic [5:0]  b_o[4];
   logic [5:0]  c_o[4];
   logic        busy_o[4];
   logic        en_o[4];
   logic        ex_o[4];
   logic [15:0] drop_o[3];
   logic [1:0]  drop3;

   change_delay_capture #(.WIDTH(6), .DLY1(10), .DLY2(5), .MODE(0), .CNTW(16)) u0 (
      .clk(clk), .rst(rst), .din(din), .b_out(b_o[0]), .c_out(c_o[0]), .busy(busy_o[0]),
      .entry_pulse(en_o[0]), .exit_pulse(ex_o[0]), .drop_cnt(drop_o[0]));
   change_delay_capture #(.WIDTH(6), .DLY1(10), .DLY2(5), .MODE(1), .CNTW(16)) u1 (
      .clk(clk), .rst(rst), .din(din), .b_out(b_o[1]), .c_out(c_o[1]), .busy(busy_o[1]),
      .entry_pulse(en_o[1]), .exit_pulse(ex_o[1]), .drop_cnt(drop_o[1]));
   change_delay_capture #(.WIDTH(6), .DLY1(1), .DLY2(1), .MODE(1), .CNTW(16)) u2 (
      .clk(clk), .rst(rst), .din(din), .b_out(b_o[2]), .c_out(c_o[2]), .busy(busy_o[2]),
      .entry_pulse(en_o[2]), .exit_pulse(ex_o[2]), .drop_cnt(drop_o[2]));
   change_delay_capture #(.WIDTH(6), .DLY1(4), .DLY2(3), .MODE(0), .CNTW(2)) u3 (
      .clk(clk), .rst(rst), .din(din), .b_out(b_o[3]), .c_out(c_o[3]), .busy(busy_o[3]),
      .entry_pulse(en_o[3]), .exit_pulse(ex_o[3]), .drop_cnt(drop3));

   int d1_a[4]   = '{10, 10, 1, 4};
   int d2_a[4]   = '{5, 5, 1, 3};
   int mode_a[4] = '{0, 1, 1, 0};
   int dmax_a[4] = '{65535, 65535, 65535, 3};

   // Model: a sequence is the edge number at which it was accepted; capture and
   // completion happen at fixed edge offsets from that acceptance edge.
   typedef struct {
      logic       active;
      int         acc;
      logic [5:0] b;
      logic [5:0] c;
      logic [5:0] prev;
      logic       busy;
      logic       en;
      logic       ex;
      int         drop;
   } model_t;

   model_t m[4];
   int     edge_no = 0;
   int     total = 0;
   int     bad = 0;
   bit     chk_en = 1'b0;
   int     ex_cnt[4] = '{0, 0, 0, 0};
   int     base = 0;

   function automatic model_t mstep(model_t mi, logic r, logic [5:0] d, int e,
                                    int d1, int d2, int mode, int dmax);
      model_t n;
      bit     chg;
      bit     was;
      n    = mi;
      n.en = 1'b0;
      n.ex = 1'b0;
      if (r) begin
         n.active = 1'b0; n.acc = 0; n.b = 6'd0; n.c = 6'd0; n.prev = 6'd0;
         n.busy = 1'b0; n.drop = 0;
         return n;
      end
      chg    = (d != mi.prev);
      n.prev = d;
      was    = mi.active;
      if (mi.active && (e == mi.acc + d1 + d2)) begin
         n.c      = mi.b;
         n.ex     = 1'b1;
         n.active = 1'b0;
      end
      if (mi.active && (e == mi.acc + d1) && !(chg && mode == 1)) n.b = d;
      if (chg) begin
         if (was) begin
            if (n.drop < dmax) n.drop = n.drop + 1;
            if (mode == 1) begin
               n.active = 1'b1; n.acc = e; n.en = 1'b1;
            end
         end else begin
            n.active = 1'b1; n.acc = e; n.en = 1'b1;
         end
      end
      n.busy = n.active;
      return n;
   endfunction

   always @(posedge clk) begin
      edge_no = edge_no + 1;
      for (int i = 0; i < 4; i++)
         m[i] = mstep(m[i], rst, din, edge_no, d1_a[i], d2_a[i], mode_a[i], dmax_a[i]);
   end

   always begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (ex_o[i] === 1'b1) ex_cnt[i] = ex_cnt[i] + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 4; i++) begin
            logic [31:0] dact;
            if (i == 3) dact = {30'd0, drop3};
            else        dact = {16'd0, drop_o[i]};
            chk($sformatf("u%0d b_out", i), {26'd0, b_o[i]}, {26'd0, m[i].b});
            chk($sformatf("u%0d c_out", i), {26'd0, c_o[i]}, {26'd0, m[i].c});
            chk($sformatf("u%0d busy", i), {31'd0, busy_o[i]}, {31'd0, m[i].busy});
            chk($sformatf("u%0d entry", i), {31'd0, en_o[i]}, {31'd0, m[i].en});
            chk($sformatf("u%0d exit", i), {31'd0, ex_o[i]}, {31'd0, m[i].ex});
            chk($sformatf("u%0d drop", i), dact, m[i].drop);
         end
      end
   end

   task automatic at_edge(input int n);
      while (edge_no < n) @(negedge clk);
   endtask

   task automatic drive_at(input int k, input logic [5:0] v);
      at_edge(base + k - 1);
      din = v;
   endtask

   // Reset occupies relative edges 1 and 2; base maps relative edges to edge_no.
   task automatic start_scn();
      int k;
      @(negedge clk);
      rst = 1'b1;
      din = 6'd0;
      k   = edge_no;
      at_edge(k + 2);
      rst  = 1'b0;
      base = k;
   endtask

   initial begin
      int s;
      start_scn();
      chk_en = 1'b1;

      // Default timing; u2 covers the minimum 1/1 delays.
      drive_at(5, 6'h15);
      at_edge(base + 5);
      chk("s1 u0 entry@5", {31'd0, en_o[0]}, 1);
      chk("s1 u0 busy@5", {31'd0, busy_o[0]}, 1);
      at_edge(base + 6);
      chk("s1 u2 b@6", {26'd0, b_o[2]}, 32'h15);
      chk("s1 u0 entry@6", {31'd0, en_o[0]}, 0);
      at_edge(base + 7);
      chk("s1 u2 c@7", {26'd0, c_o[2]}, 32'h15);
      chk("s1 u2 exit@7", {31'd0, ex_o[2]}, 1);
      at_edge(base + 14);
      chk("s1 u0 b@14", {26'd0, b_o[0]}, 0);
      at_edge(base + 15);
      chk("s1 u0 b@15", {26'd0, b_o[0]}, 32'h15);
      chk("s1 model b@15", {26'd0, m[0].b}, 32'h15);
      at_edge(base + 19);
      chk("s1 u0 busy@19", {31'd0, busy_o[0]}, 1);
      chk("s1 u0 c@19", {26'd0, c_o[0]}, 0);
      at_edge(base + 20);
      chk("s1 u0 c@20", {26'd0, c_o[0]}, 32'h15);
      chk("s1 u0 exit@20", {31'd0, ex_o[0]}, 1);
      chk("s1 u0 busy@20", {31'd0, busy_o[0]}, 0);
      at_edge(base + 21);
      chk("s1 u0 exit@21", {31'd0, ex_o[0]}, 0);

      // Capture takes the value present at the capture edge.
      start_scn();
      drive_at(5, 6'h01);
      drive_at(9, 6'h2A);
      at_edge(base + 15);
      chk("s2 u0 b@15", {26'd0, b_o[0]}, 32'h2A);
      at_edge(base + 20);
      chk("s2 u0 c@20", {26'd0, c_o[0]}, 32'h2A);
      chk("s2 u0 drop", {16'd0, drop_o[0]}, 1);

      // MODE 1 restart.
      start_scn();
      s = ex_cnt[1];
      drive_at(5, 6'h03);
      drive_at(12, 6'h07);
      at_edge(base + 12);
      chk("s3 u1 entry@12", {31'd0, en_o[1]}, 1);
      at_edge(base + 15);
      chk("s3 u1 b@15", {26'd0, b_o[1]}, 0);
      chk("s3 u0 b@15", {26'd0, b_o[0]}, 32'h07);
      at_edge(base + 22);
      chk("s3 u1 b@22", {26'd0, b_o[1]}, 32'h07);
      at_edge(base + 27);
      chk("s3 u1 c@27", {26'd0, c_o[1]}, 32'h07);
      chk("s3 u1 drop", {16'd0, drop_o[1]}, 1);
      at_edge(base + 30);
      chk("s3 u1 exits", ex_cnt[1] - s, 1);

      // Change on the completing edge is treated as busy.
      start_scn();
      drive_at(5, 6'h11);
      drive_at(20, 6'h12);
      drive_at(21, 6'h13);
      at_edge(base + 20);
      chk("s4 u0 exit@20", {31'd0, ex_o[0]}, 1);
      chk("s4 u0 c@20", {26'd0, c_o[0]}, 32'h11);
      chk("s4 u0 drop@20", {16'd0, drop_o[0]}, 1);
      chk("s4 model drop", m[0].drop, 1);
      at_edge(base + 21);
      chk("s4 u0 entry@21", {31'd0, en_o[0]}, 1);

      // Reset mid-sequence aborts with no exit pulse.
      start_scn();
      drive_at(5, 6'h21);
      drive_at(25, 6'h22);
      drive_at(28, 6'h23);
      at_edge(base + 31);
      chk("s5 u0 drop@31", {16'd0, drop_o[0]}, 1);
      chk("s5 u0 c@31", {26'd0, c_o[0]}, 32'h21);
      rst = 1'b1;
      at_edge(base + 32);
      chk("s5 u0 b@32", {26'd0, b_o[0]}, 0);
      chk("s5 u0 c@32", {26'd0, c_o[0]}, 0);
      chk("s5 u0 busy@32", {31'd0, busy_o[0]}, 0);
      chk("s5 u0 drop@32", {16'd0, drop_o[0]}, 0);
      rst = 1'b0;
      din = 6'h3C;
      s = ex_cnt[0];
      at_edge(base + 33);
      chk("s5 u0 entry@33", {31'd0, en_o[0]}, 1);
      at_edge(base + 45);
      chk("s5 u0 no exit", ex_cnt[0] - s, 0);

      // Saturation of a 2-bit drop counter (u3, DLY1=4, DLY2=3).
      start_scn();
      drive_at(5, 6'h01);
      for (int k = 6; k <= 10; k++) drive_at(k, 6'(k - 4));
      at_edge(base + 8);
      chk("s6 u3 drop@8", {30'd0, drop3}, 3);
      at_edge(base + 10);
      chk("s6 u3 drop@10", {30'd0, drop3}, 3);
      at_edge(base + 12);
      chk("s6 u3 c@12", {26'd0, c_o[3]}, 32'h05);

      // Random traffic: a busy phase then a sparse phase, with rare resets.
      start_scn();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 99) < ((k < 1500) ? 12 : 3)) din = 6'($urandom_range(0, 63));
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
